sseg_scan_decoder: RTL and testbench
====================================

Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the parking meter's time-multiplexed 7-segment driver.
- Watches the scanned an/sseg bus, waits for each anode dwell to settle, and decodes the active-low segment pattern to a BCD digit or blank.
- Reassembles the 4-digit 16-bit value plus a blank mask, and flags illegal patterns and a stalled scan.
- Used as an in-fabric display monitor and as the checker model in display-path benches.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles an and sseg must stay unchanged before a dwell is sampled (minimum 2).
- TIMEOUT_CYCLES, 2_000_000: cycles without any sampled dwell before stale asserts.
- CNT_W, 21: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- an  in  4  anode enables, active-low; an[3] is the leftmost digit.
- sseg  in  7  segments, active-low; sseg[0]=a through sseg[6]=g.
- value  out  16  last complete frame; digit k at [4k+3:4k]; 0 where the digit is blank or illegal.
- blank  out  4  per-digit blank flag of the last frame (sseg==7'h7F).
- frame_valid  out  1  one-cycle pulse when value, blank and frame_error update.
- frame_error  out  1  last frame contained an illegal segment pattern.
- an_error  out  1  one-cycle pulse on a settled dwell with more than one anode low.
- stale  out  1  level; no dwell sampled for TIMEOUT_CYCLES.

Behaviour:
- Reset values: value=0, blank=0, frame_valid=0, frame_error=0, an_error=0, stale=1. Reset also clears shadow digits, seen mask, stability counter and timeout counter.
- Decode table (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F. Any other code is illegal and decodes to digit 0 with an illegal bit set.
- Registers prev_an and prev_sseg are captured every cycle.
- Stability FSM has two states:
  - WAIT_STABLE: stab_cnt increments while {an,sseg}=={prev_an,prev_sseg}. Any change resets stab_cnt to 0. When stab_cnt reaches SETTLE_CYCLES-1 and the inputs are still equal, sample this cycle and go to SAMPLED.
  - SAMPLED: hold until {an,sseg} changes, then go to WAIT_STABLE with stab_cnt=0. This guarantees exactly one sample per dwell.
- A change on the same cycle the count would expire produces no sample and restarts the count.
- Sample action:
  - an==4'hF: idle. Nothing is recorded, the timeout is not reset.
  - Exactly one bit low: write the decoded digit, blank bit and illegal bit into the shadow slot, set seen[k], clear the timeout counter, clear stale.
  - Two or more bits low: pulse an_error next cycle. Nothing is recorded and the timeout is not reset.
- A digit sampled again before the frame completes overwrites its shadow slot; seen is unchanged.
- Frame completion: on the cycle after seen becomes 4'hF, in one registered update:
  - value, blank and frame_error (OR of shadow illegal bits) load from the shadow;
  - frame_valid pulses for one cycle;
  - seen clears.
- Latency: frame_valid follows the completing sample by exactly 1 cycle.
- Timeout: the counter saturates at TIMEOUT_CYCLES and sets stale; a valid one-hot sample clears both.
- Reset mid-frame discards the partial frame; no frame_valid is emitted for it.
- A fully blanked display (flash off phase) yields blank=4'hF, value=0, frame_error=0 with a normal frame_valid.

Decomposition:
- Shared package sseg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK localparams (active-low codes above);
  - the segment bit-order constant;
  - the digit-field width (4).
- Sub-module sseg_digit_decode: combinational, sseg[6:0] -> digit[3:0], is_blank, is_illegal. It is reused by the display-driver bench.
- The top holds the stability FSM, shadow registers, seen mask, frame register and timeout counter.

Test Plan:
- Scan 1,2,3,4 with an order E,D,B,7 and 10-cycle dwells, SETTLE_CYCLES=4 -> frame_valid once per 4 dwells, value=16'h1234, blank=0, frame_error=0.
- Dwell of 3 cycles (shorter than SETTLE_CYCLES) on digit 1 inside a scan of 9,9,9,9 -> that dwell is ignored; frame completes on the next full scan with value=16'h9999.
- All digits sseg=7F -> value=0, blank=4'hF, frame_error=0. Then sseg=7'h7E on digit 2 -> frame_error=1 and value[11:8]=0.
- an=4'b1100 held 10 cycles -> an_error pulses exactly once, seen unchanged, no frame_valid.
- Scan stops with an=F; TIMEOUT_CYCLES=100 -> stale=1 at 100 cycles after the last sample. The next valid dwell clears stale one cycle after sampling.
- Assert reset after 2 of 4 digits captured, then scan 5,6,7,8 -> no frame from the partial scan; first frame_valid shows 16'h5678, reset values are checked during reset.

Source files
------------

// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared constants for the 7-segment scan decoder and its decode helper.
// Segment codes are active-low with bit 0 = segment a through bit 6 = g.
// No ports (package).
// ---------------------------------------------------------------------------
package sseg_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Segment bit order within the sseg bus: a is bit 0, g is bit 6.
    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        WAIT_STABLE = 1'b0,
        SAMPLED     = 1'b1
    } stab_state_e;

endpackage

// File: rtl/sseg_digit_decode.sv
// ---------------------------------------------------------------------------
// sseg_digit_decode
// Combinational decode of one active-low 7-segment pattern to a BCD digit.
// Ports:
//   sseg_i       [6:0]  active-low segment pattern
//   digit_o      [3:0]  decoded digit (0 for blank or illegal patterns)
//   is_blank_o          pattern is all segments off
//   is_illegal_o        pattern is neither a digit nor blank
// ---------------------------------------------------------------------------
import sseg_pkg::*;

module sseg_digit_decode (
    input  logic [SEG_W-1:0]   sseg_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               is_blank_o,
    output logic               is_illegal_o
);

    always_comb begin
        digit_o      = 4'd0;
        is_blank_o   = 1'b0;
        is_illegal_o = 1'b0;
        case (sseg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: is_blank_o = 1'b1;
            default:   is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// sseg_scan_decoder
// Watches a time-multiplexed 4-digit 7-segment bus, samples each anode dwell
// once it has settled, and reassembles the displayed 16-bit BCD value.
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous active-high reset
//   an_i       [3:0] anode enables, active-low, an_i[3] = leftmost digit
//   sseg_i     [6:0] segments, active-low, bit 0 = a .. bit 6 = g
//   value_o   [15:0] last complete frame, digit k at [4k+3:4k]
//   blank_o    [3:0] per-digit blank flags of the last frame
//   frame_valid_o    one-cycle pulse when value/blank/frame_error update
//   frame_error_o    last frame held an illegal segment pattern
//   an_error_o       one-cycle pulse on a settled dwell with >1 anode low
//   stale_o          no dwell sampled for TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
import sseg_pkg::*;

module sseg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [3:0]         an_i,
    input  logic [SEG_W-1:0]   sseg_i,
    output logic [15:0]        value_o,
    output logic [3:0]         blank_o,
    output logic               frame_valid_o,
    output logic               frame_error_o,
    output logic               an_error_o,
    output logic               stale_o
);

    localparam int STAB_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [3:0]         prev_an_q;
    logic [SEG_W-1:0]   prev_sseg_q;
    stab_state_e        state_q;
    logic [STAB_W-1:0]  stab_cnt_q;
    logic [15:0]        shadow_value_q;
    logic [3:0]         shadow_blank_q;
    logic [3:0]         shadow_illegal_q;
    logic [3:0]         seen_q;
    logic [3:0]         seen_d;
    logic [15:0]        value_q;
    logic [3:0]         blank_q;
    logic               frame_valid_q;
    logic               frame_error_q;
    logic               an_error_q;
    logic               stale_q;
    logic [CNT_W-1:0]   timeout_q;

    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_blank;
    logic               dec_illegal;
    logic               inputs_same;
    logic               sample_fire;
    logic [3:0]         an_low;
    logic               an_onehot;
    logic               valid_sample;
    logic               bad_sample;
    logic               frame_done;

    sseg_digit_decode u_decode (
        .sseg_i       (sseg_i),
        .digit_o      (dec_digit),
        .is_blank_o   (dec_blank),
        .is_illegal_o (dec_illegal)
    );

    // A sample fires only when the settle count expires and the inputs are
    // still unchanged on that same cycle; a late change restarts the count.
    always_comb begin
        inputs_same  = (an_i == prev_an_q) && (sseg_i == prev_sseg_q);
        sample_fire  = (state_q == WAIT_STABLE) && inputs_same && (stab_cnt_q == STAB_LAST);
        an_low       = ~an_i;
        an_onehot    = (an_low != 4'h0) && ((an_low & (an_low - 4'd1)) == 4'h0);
        valid_sample = sample_fire && an_onehot;
        bad_sample   = sample_fire && (an_low != 4'h0) && !an_onehot;
        frame_done   = (seen_q == 4'hF);
        // Clearing on completion and setting from a new sample may coincide.
        seen_d       = (frame_done ? 4'h0 : seen_q) | (valid_sample ? an_low : 4'h0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_an_q        <= 4'hF;
            prev_sseg_q      <= SEG_BLANK;
            state_q          <= WAIT_STABLE;
            stab_cnt_q       <= '0;
            shadow_value_q   <= '0;
            shadow_blank_q   <= '0;
            shadow_illegal_q <= '0;
            seen_q           <= '0;
            value_q          <= '0;
            blank_q          <= '0;
            frame_valid_q    <= 1'b0;
            frame_error_q    <= 1'b0;
            an_error_q       <= 1'b0;
            stale_q          <= 1'b1;
            timeout_q        <= '0;
        end else begin
            prev_an_q   <= an_i;
            prev_sseg_q <= sseg_i;

            case (state_q)
                WAIT_STABLE: begin
                    if (!inputs_same) begin
                        stab_cnt_q <= '0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        stab_cnt_q <= '0;
                        state_q    <= SAMPLED;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + 1'b1;
                    end
                end
                SAMPLED: begin
                    if (!inputs_same) begin
                        stab_cnt_q <= '0;
                        state_q    <= WAIT_STABLE;
                    end
                end
                default: begin
                    stab_cnt_q <= '0;
                    state_q    <= WAIT_STABLE;
                end
            endcase

            if (valid_sample) begin
                for (int k = 0; k < 4; k++) begin
                    if (an_low[k]) begin
                        shadow_value_q[4*k +: 4] <= dec_digit;
                        shadow_blank_q[k]        <= dec_blank;
                        shadow_illegal_q[k]      <= dec_illegal;
                    end
                end
            end
            seen_q <= seen_d;

            an_error_q    <= bad_sample;
            frame_valid_q <= frame_done;
            if (frame_done) begin
                value_q       <= shadow_value_q;
                blank_q       <= shadow_blank_q;
                frame_error_q <= |shadow_illegal_q;
            end

            // Idle (all anodes off) and multi-anode dwells do not count as
            // activity, so a stuck or dark display still goes stale.
            if (valid_sample) begin
                timeout_q <= '0;
                stale_q   <= 1'b0;
            end else if (timeout_q < TIMEOUT_MAX - 1'b1) begin
                timeout_q <= timeout_q + 1'b1;
            end else begin
                timeout_q <= TIMEOUT_MAX;
                stale_q   <= 1'b1;
            end
        end
    end

    assign value_o       = value_q;
    assign blank_o       = blank_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_error_o = frame_error_q;
    assign an_error_o    = an_error_q;
    assign stale_o       = stale_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_decoder
// Directed bench for sseg_scan_decoder with SETTLE_CYCLES=4 and
// TIMEOUT_CYCLES=100. Inputs change on the falling edge; outputs are read on
// the falling edge as well, half a period away from the active edge.
// ---------------------------------------------------------------------------
import sseg_pkg::*;

module tb_sseg_scan_decoder;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        frameValid;
    logic        frameError;
    logic        anError;
    logic        stale;

    int compareCount = 0;
    int failCount    = 0;
    int fvCount      = 0;
    int aeCount      = 0;

    sseg_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .an_i          (an),
        .sseg_i        (sseg),
        .value_o       (value),
        .blank_o       (blank),
        .frame_valid_o (frameValid),
        .frame_error_o (frameError),
        .an_error_o    (anError),
        .stale_o       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, updated shortly after each rising edge so the falling
    // edge reads in the main sequence always see settled counts.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (frameValid) fvCount++;
            if (anError)    aeCount++;
        end
    end

    // Drive one dwell and let it run for the given number of falling edges.
    task automatic applyStimulus(input logic [3:0] anVal, input logic [6:0] segVal, input int cycles);
        an   = anVal;
        sseg = segVal;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        an    = 4'hF;
        sseg  = SEG_BLANK;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_value",  32'(value), 32'h0);
        checkOutput("rst_blank",  32'(blank), 32'h0);
        checkOutput("rst_fvalid", 32'(frameValid), 32'h0);
        checkOutput("rst_ferr",   32'(frameError), 32'h0);
        checkOutput("rst_aerr",   32'(anError), 32'h0);
        checkOutput("rst_stale",  32'(stale), 32'h1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] scan 1234");
        applyStimulus(4'hE, SEG_4, 10);
        applyStimulus(4'hD, SEG_3, 10);
        applyStimulus(4'hB, SEG_2, 10);
        applyStimulus(4'h7, SEG_1, 10);
        checkOutput("s1_fvcount", 32'(fvCount), 32'd1);
        checkOutput("s1_value",   32'(value), 32'h1234);
        checkOutput("s1_blank",   32'(blank), 32'h0);
        checkOutput("s1_ferr",    32'(frameError), 32'h0);
        checkOutput("s1_stale",   32'(stale), 32'h0);

        // Second scan: sample lands on the 5th rising edge of the last
        // dwell, frame_valid is visible one cycle later for one cycle.
        applyStimulus(4'hE, SEG_4, 10);
        applyStimulus(4'hD, SEG_3, 10);
        applyStimulus(4'hB, SEG_2, 10);
        applyStimulus(4'h7, SEG_1, 5);
        checkOutput("lat_before", 32'(frameValid), 32'h0);
        applyStimulus(4'h7, SEG_1, 1);
        checkOutput("lat_pulse",  32'(frameValid), 32'h1);
        applyStimulus(4'h7, SEG_1, 1);
        checkOutput("lat_after",  32'(frameValid), 32'h0);
        applyStimulus(4'h7, SEG_1, 3);
        checkOutput("s2_fvcount", 32'(fvCount), 32'd2);

        $display("[TB] short dwell ignored");
        applyStimulus(4'hE, SEG_9, 10);
        applyStimulus(4'hD, SEG_1, 3);
        applyStimulus(4'hB, SEG_9, 10);
        applyStimulus(4'h7, SEG_9, 10);
        checkOutput("short_noframe", 32'(fvCount), 32'd2);
        applyStimulus(4'hE, SEG_9, 10);
        applyStimulus(4'hD, SEG_9, 10);
        checkOutput("short_fvcount", 32'(fvCount), 32'd3);
        checkOutput("short_value",   32'(value), 32'h9999);

        $display("[TB] blank and illegal frames");
        applyStimulus(4'hE, SEG_BLANK, 10);
        applyStimulus(4'hD, SEG_BLANK, 10);
        applyStimulus(4'hB, SEG_BLANK, 10);
        applyStimulus(4'h7, SEG_BLANK, 10);
        checkOutput("blank_fvcount", 32'(fvCount), 32'd4);
        checkOutput("blank_value",   32'(value), 32'h0);
        checkOutput("blank_blank",   32'(blank), 32'hF);
        checkOutput("blank_ferr",    32'(frameError), 32'h0);
        applyStimulus(4'hE, SEG_4, 10);
        applyStimulus(4'hD, SEG_3, 10);
        applyStimulus(4'hB, 7'h7E, 10);
        applyStimulus(4'h7, SEG_1, 10);
        checkOutput("illeg_fvcount", 32'(fvCount), 32'd5);
        checkOutput("illeg_value",   32'(value), 32'h1034);
        checkOutput("illeg_blank",   32'(blank), 32'h0);
        checkOutput("illeg_ferr",    32'(frameError), 32'h1);

        $display("[TB] multiple anodes low");
        applyStimulus(4'hE, SEG_5, 10);
        applyStimulus(4'hC, SEG_2, 10);
        checkOutput("anerr_count",   32'(aeCount), 32'd1);
        checkOutput("anerr_level",   32'(anError), 32'h0);
        checkOutput("anerr_noframe", 32'(fvCount), 32'd5);
        applyStimulus(4'hD, SEG_6, 10);
        applyStimulus(4'hB, SEG_7, 10);
        applyStimulus(4'h7, SEG_8, 10);
        checkOutput("anerr_fvcount", 32'(fvCount), 32'd6);
        checkOutput("anerr_value",   32'(value), 32'h8765);
        checkOutput("anerr_ferr",    32'(frameError), 32'h0);
        checkOutput("anerr_final",   32'(aeCount), 32'd1);

        // Last valid sample was the 5th rising edge of the previous dwell;
        // stale rises on the 100th rising edge after it.
        $display("[TB] stale timeout");
        checkOutput("stale_clear0", 32'(stale), 32'h0);
        applyStimulus(4'hF, SEG_BLANK, 94);
        checkOutput("stale_edge99", 32'(stale), 32'h0);
        applyStimulus(4'hF, SEG_BLANK, 1);
        checkOutput("stale_edge100", 32'(stale), 32'h1);
        applyStimulus(4'hE, SEG_1, 4);
        checkOutput("stale_presample", 32'(stale), 32'h1);
        applyStimulus(4'hE, SEG_1, 1);
        checkOutput("stale_cleared", 32'(stale), 32'h0);
        applyStimulus(4'hE, SEG_1, 5);

        $display("[TB] reset mid-frame");
        applyStimulus(4'hD, SEG_2, 10);
        reset = 1'b1;
        an    = 4'hF;
        sseg  = SEG_BLANK;
        repeat (2) @(negedge clk);
        checkOutput("mid_value",  32'(value), 32'h0);
        checkOutput("mid_blank",  32'(blank), 32'h0);
        checkOutput("mid_fvalid", 32'(frameValid), 32'h0);
        checkOutput("mid_ferr",   32'(frameError), 32'h0);
        checkOutput("mid_aerr",   32'(anError), 32'h0);
        checkOutput("mid_stale",  32'(stale), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(4'hB, SEG_6, 10);
        applyStimulus(4'h7, SEG_5, 10);
        checkOutput("mid_noframe", 32'(fvCount), 32'd6);
        applyStimulus(4'hE, SEG_8, 10);
        applyStimulus(4'hD, SEG_7, 10);
        checkOutput("mid_fvcount", 32'(fvCount), 32'd7);
        checkOutput("mid_newval",  32'(value), 32'h5678);
        checkOutput("mid_newblk",  32'(blank), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
